// File: rtl/decode_ctrl_stage_if.sv
// Bus bundle for the decode control stage: upstream instruction handshake,
// flush, downstream control-bundle handshake and the statistics counters.
//
// Handshake: a word moves on a rising clk edge exactly when its valid and the
// matching ready are both 1 (in_valid/in_ready upstream, out_valid/out_ready
// downstream). A producer holding valid=1 keeps its payload stable until the
// transfer happens. ready may depend on valid in the same cycle; valid never
// depends on ready.
interface decode_ctrl_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [31:0]      in_instr;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             reg_alu_mux;
  logic             mem_read;
  logic             mem_write;
  logic [3:0]       alu_op;
  logic             reg_write;
  logic             data_reg_mux;
  logic             branch_ctrl;
  logic             jump;
  logic             illegal;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [XLEN-1:0]  imm;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] illegal_cnt;

  // Decode stage side.
  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, reg_alu_mux, mem_read, mem_write, alu_op,
           reg_write, data_reg_mux, branch_ctrl, jump, illegal, rd, rs1, rs2,
           imm, stall_cnt, illegal_cnt
  );

  // Fetch / execute environment side.
  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, reg_alu_mux, mem_read, mem_write, alu_op,
           reg_write, data_reg_mux, branch_ctrl, jump, illegal, rd, rs1, rs2,
           imm, stall_cnt, illegal_cnt
  );
endinterface

// File: rtl/decode_ctrl_stage.sv
// RV32 decode control stage: turns a raw instruction into a registered
// control bundle, inserts a one-cycle bubble on load-use dependencies and
// keeps saturating counts of stall cycles and illegal instructions.
module decode_ctrl_stage #(
  parameter int XLEN       = 32,
  parameter int CNT_W      = 16,
  parameter bit ENABLE_JAL = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  decode_ctrl_stage_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Instruction fields of the incoming word.
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] f_rd;
  logic [4:0] f_rs1;
  logic [4:0] f_rs2;

  assign opcode = bus.in_instr[6:0];
  assign f_rd   = bus.in_instr[11:7];
  assign funct3 = bus.in_instr[14:12];
  assign f_rs1  = bus.in_instr[19:15];
  assign f_rs2  = bus.in_instr[24:20];
  assign funct7 = bus.in_instr[31:25];

  // Immediates per format, sign-extended from instr[31] by the signed cast.
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign imm_i = XLEN'($signed(bus.in_instr[31:20]));
  assign imm_s = XLEN'($signed({bus.in_instr[31:25], bus.in_instr[11:7]}));
  assign imm_b = XLEN'($signed({bus.in_instr[31], bus.in_instr[7],
                                bus.in_instr[30:25], bus.in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({bus.in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({bus.in_instr[31], bus.in_instr[19:12],
                                bus.in_instr[20], bus.in_instr[30:21], 1'b0}));

  // ALU operation selected by funct3 alone (funct7 = 0000000 flavour).
  function automatic alu_op_e base_alu(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Decoded, not yet registered bundle.
  logic            d_reg_alu_mux;
  logic            d_mem_read;
  logic            d_mem_write;
  alu_op_e         d_alu_op;
  logic            d_reg_write;
  logic            d_data_reg_mux;
  logic            d_branch_ctrl;
  logic            d_jump;
  logic            d_illegal;
  logic [XLEN-1:0] d_imm;

  // Registered bundle.
  logic            out_valid_q;
  logic            q_reg_alu_mux;
  logic            q_mem_read;
  logic            q_mem_write;
  logic [3:0]      q_alu_op;
  logic            q_reg_write;
  logic            q_data_reg_mux;
  logic            q_branch_ctrl;
  logic            q_jump;
  logic            q_illegal;
  logic [4:0]      q_rd;
  logic [4:0]      q_rs1;
  logic [4:0]      q_rs2;
  logic [XLEN-1:0] q_imm;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] illegal_cnt_q;

  logic uses_rs1;
  logic uses_rs2;
  logic hazard;
  logic in_ready;
  logic accept;

  // Opcode decode into the next control bundle; illegal words are scrubbed.
  always_comb begin
    d_reg_alu_mux  = 1'b0;
    d_mem_read     = 1'b0;
    d_mem_write    = 1'b0;
    d_alu_op       = ALU_ADD;
    d_reg_write    = 1'b0;
    d_data_reg_mux = 1'b0;
    d_branch_ctrl  = 1'b0;
    d_jump         = 1'b0;
    d_illegal      = 1'b0;
    d_imm          = '0;
    case (opcode)
      OPC_R: begin
        d_reg_write = 1'b1;
        if (funct7 == F7_BASE) begin
          d_alu_op = base_alu(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          d_alu_op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          d_alu_op = ALU_SRA;
        end else begin
          d_illegal = 1'b1;
        end
      end
      OPC_I: begin
        d_reg_alu_mux = 1'b1;
        d_reg_write   = 1'b1;
        d_imm         = imm_i;
        d_alu_op      = base_alu(funct3);
        // Shift-immediates reuse imm[11:5] as a funct7-like qualifier.
        if (funct3 == 3'b001 && funct7 != F7_BASE) begin
          d_illegal = 1'b1;
        end
        if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) begin
            d_alu_op = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            d_illegal = 1'b1;
          end
        end
      end
      OPC_LD: begin
        d_mem_read     = 1'b1;
        d_data_reg_mux = 1'b1;
        d_reg_alu_mux  = 1'b1;
        d_reg_write    = 1'b1;
        d_imm          = imm_i;
      end
      OPC_ST: begin
        d_mem_write   = 1'b1;
        d_reg_alu_mux = 1'b1;
        d_imm         = imm_s;
      end
      OPC_BR: begin
        d_alu_op      = ALU_SUB;
        d_branch_ctrl = 1'b1;
        d_imm         = imm_b;
      end
      OPC_LUI: begin
        d_reg_alu_mux = 1'b1;
        d_reg_write   = 1'b1;
        d_imm         = imm_u;
      end
      OPC_JAL: begin
        if (ENABLE_JAL) begin
          d_jump      = 1'b1;
          d_reg_write = 1'b1;
          d_imm       = imm_j;
        end else begin
          d_illegal = 1'b1;
        end
      end
      default: d_illegal = 1'b1;
    endcase
    if (d_illegal) begin
      d_reg_alu_mux  = 1'b0;
      d_mem_read     = 1'b0;
      d_mem_write    = 1'b0;
      d_alu_op       = ALU_ADD;
      d_reg_write    = 1'b0;
      d_data_reg_mux = 1'b0;
      d_branch_ctrl  = 1'b0;
      d_jump         = 1'b0;
      d_imm          = '0;
    end
  end

  // Load-use detection against the held bundle and the resulting ready.
  always_comb begin
    uses_rs1 = (opcode != OPC_LUI) && (opcode != OPC_JAL);
    uses_rs2 = (opcode == OPC_R) || (opcode == OPC_ST) || (opcode == OPC_BR);
    hazard   = out_valid_q && q_mem_read && (q_rd != 5'd0) && bus.in_valid &&
               ((uses_rs1 && (f_rs1 == q_rd)) || (uses_rs2 && (f_rs2 == q_rd)));
    // rst_n gates ready so nothing looks acceptable while reset is held.
    in_ready = rst_n && (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
    accept   = bus.in_valid && in_ready;
  end

  // Bundle register: loads on accept, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg_alu_mux  <= 1'b0;
      q_mem_read     <= 1'b0;
      q_mem_write    <= 1'b0;
      q_alu_op       <= 4'd0;
      q_reg_write    <= 1'b0;
      q_data_reg_mux <= 1'b0;
      q_branch_ctrl  <= 1'b0;
      q_jump         <= 1'b0;
      q_illegal      <= 1'b0;
      q_rd           <= 5'd0;
      q_rs1          <= 5'd0;
      q_rs2          <= 5'd0;
      q_imm          <= '0;
    end else if (accept) begin
      q_reg_alu_mux  <= d_reg_alu_mux;
      q_mem_read     <= d_mem_read;
      q_mem_write    <= d_mem_write;
      q_alu_op       <= d_alu_op;
      q_reg_write    <= d_reg_write;
      q_data_reg_mux <= d_data_reg_mux;
      q_branch_ctrl  <= d_branch_ctrl;
      q_jump         <= d_jump;
      q_illegal      <= d_illegal;
      q_rd           <= f_rd;
      q_rs1          <= f_rs1;
      q_rs2          <= f_rs2;
      q_imm          <= d_imm;
    end
  end

  // Output valid: flush wins, then accept, then drain on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Saturating count of cycles a valid input was held back by a load-use hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (bus.in_valid && hazard && !bus.flush && stall_cnt_q != CNT_MAX) begin
      stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end
  end

  // Saturating count of accepted illegal instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt_q <= '0;
    end else if (accept && d_illegal && illegal_cnt_q != CNT_MAX) begin
      illegal_cnt_q <= illegal_cnt_q + CNT_ONE;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.reg_alu_mux  = q_reg_alu_mux;
  assign bus.mem_read     = q_mem_read;
  assign bus.mem_write    = q_mem_write;
  assign bus.alu_op       = q_alu_op;
  assign bus.reg_write    = q_reg_write;
  assign bus.data_reg_mux = q_data_reg_mux;
  assign bus.branch_ctrl  = q_branch_ctrl;
  assign bus.jump         = q_jump;
  assign bus.illegal      = q_illegal;
  assign bus.rd           = q_rd;
  assign bus.rs1          = q_rs1;
  assign bus.rs2          = q_rs2;
  assign bus.imm          = q_imm;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.illegal_cnt  = illegal_cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: directed scenarios followed by random traffic,
// all checked by a scoreboard fed from a spec-level reference model.
module tb_decode_ctrl_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int BW    = 27 + XLEN;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_ST  = 7'h23;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_LUI = 7'h37;
  localparam logic [6:0] OP_JAL = 7'h6F;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_ctrl_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  decode_ctrl_stage #(.XLEN(XLEN), .CNT_W(CNT_W), .ENABLE_JAL(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] exp_q[$];

  // Reference model state.
  bit               m_ov    = 1'b0;
  logic [31:0]      m_held  = 32'h0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_ill   = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected bundle straight from the ISA rules, immediates via integer sign extension.
  function automatic logic [BW-1:0] ref_bundle(input logic [31:0] i);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    int op;
    bit ill, mux, mr, mw, rw, dm, br, jp;
    longint v;
    int base_op [8];
    logic [XLEN-1:0] imm;
    base_op = '{0, 5, 8, 9, 4, 6, 3, 2};
    opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    ill = 0; mux = 0; mr = 0; mw = 0; rw = 0; dm = 0; br = 0; jp = 0;
    op = 0; v = 0;
    case (opc)
      OP_R: begin
        rw = 1;
        if (f7 == 7'h00) op = base_op[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) op = 1;
        else if (f7 == 7'h20 && f3 == 3'd5) op = 7;
        else ill = 1;
      end
      OP_I: begin
        mux = 1; rw = 1; op = base_op[f3];
        v = longint'($signed(i[31:20]));
        if (f3 == 3'd1 && f7 != 7'h00) ill = 1;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) op = 7;
          else if (f7 != 7'h00) ill = 1;
        end
      end
      OP_LD: begin
        mr = 1; dm = 1; mux = 1; rw = 1;
        v = longint'($signed(i[31:20]));
      end
      OP_ST: begin
        mw = 1; mux = 1;
        v = longint'($signed({i[31:25], i[11:7]}));
      end
      OP_BR: begin
        op = 1; br = 1;
        v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      end
      OP_LUI: begin
        mux = 1; rw = 1;
        v = longint'($signed({i[31:12], 12'b0}));
      end
      OP_JAL: begin
        jp = 1; rw = 1;
        v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      end
      default: ill = 1;
    endcase
    if (ill) begin
      op = 0; mux = 0; mr = 0; mw = 0; rw = 0; dm = 0; br = 0; jp = 0; v = 0;
    end
    imm = v[XLEN-1:0];
    return {ill, mux, mr, mw, 4'(op), rw, dm, br, jp, i[11:7], i[19:15], i[24:20], imm};
  endfunction

  function automatic logic [BW-1:0] dut_bundle();
    return {bus.illegal, bus.reg_alu_mux, bus.mem_read, bus.mem_write, bus.alu_op,
            bus.reg_write, bus.data_reg_mux, bus.branch_ctrl, bus.jump,
            bus.rd, bus.rs1, bus.rs2, bus.imm};
  endfunction

  // Load-use: held load writing a nonzero rd that the incoming word reads.
  function automatic bit m_hazard();
    logic [6:0] opc;
    logic [4:0] lrd;
    bit dep1, dep2;
    opc  = bus.in_instr[6:0];
    lrd  = m_held[11:7];
    dep1 = (opc != OP_LUI) && (opc != OP_JAL) && (bus.in_instr[19:15] == lrd);
    dep2 = (opc == OP_R || opc == OP_ST || opc == OP_BR) && (bus.in_instr[24:20] == lrd);
    return m_ov && (m_held[6:0] == OP_LD) && (lrd != 5'd0) && bus.in_valid && (dep1 || dep2);
  endfunction

  function automatic bit m_ready();
    return (!m_ov || bus.out_ready) && !m_hazard() && !bus.flush;
  endfunction

  // Reference model: advances on each edge, pushes expected bundles on accept.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ov = 1'b0;
      m_stall = '0;
      m_ill = '0;
      exp_q.delete();
    end else begin
      bit hz, rdy;
      logic [BW-1:0] eb;
      hz  = m_hazard();
      rdy = m_ready();
      if (hz && !bus.flush && int'(m_stall) < (1 << CNT_W) - 1) m_stall = m_stall + 1'b1;
      if (bus.flush) begin
        m_ov = 1'b0;
      end else if (bus.in_valid && rdy) begin
        eb = ref_bundle(bus.in_instr);
        exp_q.push_back(eb);
        m_ov = 1'b1;
        m_held = bus.in_instr;
        if (eb[BW-1] && int'(m_ill) < (1 << CNT_W) - 1) m_ill = m_ill + 1'b1;
      end else if (bus.out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  // Monitor: compares handshake, counters and the presented bundle each cycle.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      chk("in_ready", bus.in_ready, m_ready());
      chk("out_valid", bus.out_valid, m_ov);
      chk("stall_cnt", bus.stall_cnt, m_stall);
      chk("illegal_cnt", bus.illegal_cnt, m_ill);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bundle: got 0x%0h expected no bundle at %0t", dut_bundle(), $time);
        end else begin
          chk("bundle", dut_bundle(), exp_q[0]);
          if (bus.flush || bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit fl);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    int k;
    logic [6:0] opc, f7;
    k = $urandom_range(0, 10);
    case (k)
      0, 1:    opc = OP_R;
      2, 3:    opc = OP_I;
      4, 5:    opc = OP_LD;
      6:       opc = OP_ST;
      7:       opc = OP_BR;
      8:       opc = OP_LUI;
      9:       opc = OP_JAL;
      default: opc = 7'($urandom_range(0, 127));
    endcase
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom_range(0, 127));
    endcase
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), opc};
  endfunction

  localparam logic [31:0] ADD_2_1_3 = 32'h0030_8133;
  localparam logic [31:0] LW_5_0_1  = 32'h0000_A283;
  localparam logic [31:0] BEQ_M4    = 32'hFE00_0EE3;
  localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

  initial begin
    logic [31:0] add_6_5_5;
    logic [31:0] lui_7;
    add_6_5_5 = {7'h00, 5'd5, 5'd5, 3'd0, 5'd6, OP_R};
    lui_7     = {20'h12345, 5'd7, OP_LUI};
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    #2;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_bundle", dut_bundle(), '0);
    chk("rst_stall_cnt", bus.stall_cnt, '0);
    chk("rst_illegal_cnt", bus.illegal_cnt, '0);

    // Release reset and present add x2,x1,x3 for the very first edge.
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = ADD_2_1_3;
    step(0, 32'h0, 1, 0);
    #2;
    chk("add_valid", bus.out_valid, 1'b1);
    chk("add_alu_op", bus.alu_op, 4'd0);
    chk("add_reg_write", bus.reg_write, 1'b1);
    chk("add_reg_alu_mux", bus.reg_alu_mux, 1'b0);
    chk("add_rd", bus.rd, 5'd2);
    chk("add_rs1", bus.rs1, 5'd1);
    chk("add_rs2", bus.rs2, 5'd3);
    chk("add_imm", bus.imm, '0);

    // Load-use: lw x5 then add x6,x5,x5.
    step(1, LW_5_0_1, 1, 0);
    step(1, add_6_5_5, 1, 0);
    #2;
    chk("lu_in_ready", bus.in_ready, 1'b0);
    chk("lu_mem_read", bus.mem_read, 1'b1);
    step(1, add_6_5_5, 1, 0);
    #2;
    chk("lu_bubble", bus.out_valid, 1'b0);
    chk("lu_stall_cnt", bus.stall_cnt, 4'd1);
    chk("lu_ready_after", bus.in_ready, 1'b1);
    step(0, 32'h0, 1, 0);
    #2;
    chk("lu_add_valid", bus.out_valid, 1'b1);
    chk("lu_add_rd", bus.rd, 5'd6);

    // beq x0,x0,-4.
    step(1, BEQ_M4, 1, 0);
    step(0, 32'h0, 1, 0);
    #2;
    chk("beq_branch", bus.branch_ctrl, 1'b1);
    chk("beq_alu_op", bus.alu_op, 4'd1);
    chk("beq_imm", bus.imm, 32'hFFFF_FFFC);

    // All-ones word is illegal.
    step(1, ALL_ONES, 1, 0);
    step(0, 32'h0, 1, 0);
    #2;
    chk("ill_flag", bus.illegal, 1'b1);
    chk("ill_reg_write", bus.reg_write, 1'b0);
    chk("ill_mem_write", bus.mem_write, 1'b0);
    chk("ill_cnt", bus.illegal_cnt, 4'd1);

    // Backpressure for 3 cycles, then flush.
    step(1, ADD_2_1_3, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step(1, lui_7, 0, 0);
      #2;
      chk("hold_valid", bus.out_valid, 1'b1);
      chk("hold_rd", bus.rd, 5'd2);
      chk("hold_in_ready", bus.in_ready, 1'b0);
    end
    step(1, lui_7, 0, 1);
    #2;
    chk("flush_in_ready", bus.in_ready, 1'b0);
    step(0, 32'h0, 1, 0);
    #2;
    chk("flush_valid", bus.out_valid, 1'b0);

    // Saturate illegal_cnt, then one more illegal.
    for (int n = 0; n < 16; n++) step(1, ALL_ONES, 1, 0);
    step(1, ALL_ONES, 1, 0);
    step(0, 32'h0, 0, 0);
    #2;
    chk("sat_illegal_cnt", bus.illegal_cnt, 4'hF);
    chk("sat_held", bus.out_valid, 1'b1);

    // Asynchronous reset while a bundle is held.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_bundle", dut_bundle(), '0);
    chk("arst_illegal_cnt", bus.illegal_cnt, '0);
    chk("arst_stall_cnt", bus.stall_cnt, '0);
    chk("arst_in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 24) == 0);
    end
    repeat (3) step(0, 32'h0, 1, 0);
    #2;
    chk("drain_queue", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width for imm output; legal values 32 or 64.
REQ-002 SHALL have parameter CNT_W, default 16, width of the saturating statistics counters.
REQ-003 SHALL have parameter ENABLE_JAL, default 1; when 0, the JAL opcode decodes as illegal.
REQ-004 SHALL have ports as follows (clock and reset first):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_instr is valid.
- in_instr  in  32  raw RV32 instruction.
- in_ready  out  1  stage accepts in_instr this cycle.
- flush  in  1  discard the held entry and refuse input.
- out_valid  out  1  registered control bundle is valid.
- out_ready  in  1  downstream consumes the bundle.
- reg_alu_mux  out  1  ALU operand B: 1 = immediate, 0 = rs2.
- mem_read  out  1  load.
- mem_write  out  1  store.
- alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- reg_write  out  1  write rd.
- data_reg_mux  out  1  write-back source: 1 = memory, 0 = ALU.
- branch_ctrl  out  1  conditional branch.
- jump  out  1  JAL.
- illegal  out  1  undecodable instruction.
- rd / rs1 / rs2  out  5 each  register fields.
- imm  out  XLEN  sign-extended immediate.
- stall_cnt  out  CNT_W  count of load-use stall cycles.
- illegal_cnt  out  CNT_W  count of accepted illegal instructions.

Function
REQ-005 SHALL decode opcodes as follows:
- 0110011 R: alu_op from funct3/funct7; reg_write=1.
- 0010011 I-ALU: reg_alu_mux=1, reg_write=1.
- 0000011 load: alu_op=ADD, mem_read=1, data_reg_mux=1, reg_alu_mux=1, reg_write=1.
- 0100011 store: alu_op=ADD, mem_write=1, reg_alu_mux=1.
- 1100011 branch: alu_op=SUB, branch_ctrl=1.
- 0110111 LUI: alu_op=ADD, reg_alu_mux=1, reg_write=1.
- 1101111 JAL: jump=1, reg_write=1.
REQ-006 SHALL flag as illegal:
- any other opcode;
- R-type funct7 not in {0000000, 0100000};
- funct7=0100000 with funct3 other than 000 or 101;
- I-ALU shift (funct3 001/101) with imm[11:5] not in {0000000, 0100000}, or 0100000 with funct3=001.
REQ-007 An illegal bundle SHALL have illegal=1 and reg_write, mem_read, mem_write, branch_ctrl and jump all 0.
REQ-008 SHALL form imm by format, sign-extended from instr[31] to XLEN:
- I: [31:20].
- S: {[31:25],[11:7]}.
- B: {[31],[7],[30:25],[11:8],0}.
- U: {[31:12],12'b0}.
- J: {[31],[19:12],[20],[30:21],0}.
- R: imm=0.
REQ-009 All bundle outputs SHALL be registered; latency from accept to out_valid SHALL be 1 cycle.
REQ-010 in_ready SHALL equal (!out_valid | out_ready) & !hazard & !flush.
REQ-011 Accept (in_valid & in_ready) SHALL load the bundle and set out_valid=1.
REQ-012 On out_valid & out_ready with no accept, out_valid SHALL clear to 0.
REQ-013 While out_valid & !out_ready, the bundle SHALL hold unchanged.
REQ-014 hazard SHALL be 1 when all of the following hold:
- out_valid=1, mem_read=1 and held rd!=0;
- in_valid=1;
- either in_instr[19:15]==rd with the incoming opcode reading rs1 (all except LUI and JAL), or in_instr[24:20]==rd with the incoming opcode reading rs2 (R, store, branch).
REQ-015 A hazard SHALL therefore insert exactly one bubble when out_ready=1: the load drains, out_valid goes to 0, and the dependent instruction is accepted the next cycle.
REQ-016 flush SHALL take priority over everything: out_valid clears to 0 next cycle and no accept occurs that cycle.
REQ-017 stall_cnt SHALL increment once per cycle with in_valid & hazard & !flush, saturating at all-ones.
REQ-018 illegal_cnt SHALL increment once per accepted illegal instruction, saturating at all-ones.
REQ-019 Counters SHALL hold at saturation and never wrap.
REQ-020 Inputs with in_valid=0 SHALL have no effect on state or counters.

Reset
REQ-021 rst_n=0 SHALL asynchronously clear out_valid, all bundle outputs, imm, stall_cnt and illegal_cnt to 0.
REQ-022 in_ready SHALL read 0 during reset.
REQ-023 After rst_n deasserts, the first rising edge SHALL be able to accept an instruction.
REQ-024 Reset asserted mid-transfer SHALL discard the held bundle with no output.

Verification
REQ-025 Issue 0x00308133 (add x2,x1,x3) with out_ready=1 -> next cycle out_valid=1, alu_op=0, reg_write=1, reg_alu_mux=0, rd=2, rs1=1, rs2=3, imm=0.
REQ-026 Issue lw x5,0(x1) (0x0000A283), then add x6,x5,x5 back-to-back with out_ready=1 -> in_ready=0 for one cycle, stall_cnt=1, one bubble cycle, then the add emitted.
REQ-027 Issue 0xFE000EE3 (beq x0,x0,-4) -> branch_ctrl=1, alu_op=1, imm=0xFFFFFFFC (0xFFFFFFFFFFFFFFFC when XLEN=64).
REQ-028 Issue 0xFFFFFFFF -> illegal=1, reg_write=0, mem_write=0, illegal_cnt increments by 1.
REQ-029 Hold out_ready=0 for 3 cycles with a bundle held -> bundle stable and in_ready=0; then assert flush -> out_valid=0 next cycle.
REQ-030 Force illegal_cnt to all-ones via 2^CNT_W illegal instructions (use CNT_W=4) -> illegal_cnt stays 0xF on the next illegal instruction; assert rst_n=0 mid-stream -> all outputs 0 immediately.
